// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the architectural PC, drives the imem
// request/ack handshake and the IF output register (delay-slot redirects, flushes).
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel
);

  typedef enum logic [0:0] {ST_FETCH = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t      state_r;
  logic [31:0] pc_r, req_addr_r, pend_pc_r, hold_pc_r, hold_instr_r;
  logic        pend_v_r, drop_r, hold_v_r, hold_adel_r;

  logic        consume_s, out_free_s, misaligned_s, ack_s, outstanding_s;
  logic [31:0] nxt_s, target_s, word_s;

  function automatic logic aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  assign consume_s     = if_valid & ~stall;
  assign out_free_s    = ~if_valid | consume_s;
  assign misaligned_s  = ~aligned(req_addr_r);
  // A misaligned address is never sent to memory; it completes at once as a faulting word.
  assign ack_s         = (state_r == ST_FETCH) & ((imem_req & imem_ack) | misaligned_s);
  assign outstanding_s = (state_r == ST_FETCH) & imem_req & ~imem_ack;
  assign nxt_s         = pend_v_r ? pend_pc_r : (pc_r + 32'd4);
  assign target_s      = redir_valid ? redir_pc : nxt_s;
  assign word_s        = misaligned_s ? 32'd0 : imem_rdata;
  assign imem_addr     = req_addr_r;

  // Fetch FSM, PC/redirect bookkeeping and the registered IF stage outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      req_addr_r   <= RESET_PC;
      pend_v_r     <= 1'b0;
      pend_pc_r    <= 32'd0;
      drop_r       <= 1'b0;
      hold_v_r     <= 1'b0;
      hold_pc_r    <= 32'd0;
      hold_instr_r <= 32'd0;
      hold_adel_r  <= 1'b0;
      imem_req     <= 1'b0;
      if_valid     <= 1'b0;
      if_pc        <= 32'd0;
      if_instr     <= 32'd0;
      if_adel      <= 1'b0;
    end else if (flush_valid) begin
      state_r  <= ST_FETCH;
      pc_r     <= flush_pc;
      pend_v_r <= 1'b0;
      hold_v_r <= 1'b0;
      if_valid <= 1'b0;
      // An unacked request must still complete; its word is discarded later.
      if (outstanding_s) begin
        drop_r   <= 1'b1;
        imem_req <= 1'b1;
      end else begin
        drop_r     <= 1'b0;
        req_addr_r <= flush_pc;
        imem_req   <= aligned(flush_pc);
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (ack_s && drop_r) begin
            drop_r     <= 1'b0;
            req_addr_r <= pc_r;
            imem_req   <= aligned(pc_r);
            if (consume_s) if_valid <= 1'b0;
          end else if (ack_s) begin
            pc_r       <= target_s;
            req_addr_r <= target_s;
            if (!redir_valid) pend_v_r <= 1'b0;
            if (out_free_s) begin
              if_valid <= 1'b1;
              if_pc    <= req_addr_r;
              if_instr <= word_s;
              if_adel  <= misaligned_s;
              imem_req <= aligned(target_s);
            end else begin
              hold_v_r     <= 1'b1;
              hold_pc_r    <= req_addr_r;
              hold_instr_r <= word_s;
              hold_adel_r  <= misaligned_s;
              imem_req     <= 1'b0;
              state_r      <= ST_HOLD;
            end
          end else begin
            imem_req <= 1'b1;
            // The in-flight word is the delay slot; park the target until it lands.
            if (redir_valid && !drop_r) begin
              pend_v_r  <= 1'b1;
              pend_pc_r <= redir_pc;
            end
            if (consume_s) if_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (redir_valid) begin
            pc_r       <= redir_pc;
            req_addr_r <= redir_pc;
          end
          if (out_free_s && hold_v_r) begin
            if_valid <= 1'b1;
            if_pc    <= hold_pc_r;
            if_instr <= hold_instr_r;
            if_adel  <= hold_adel_r;
            hold_v_r <= 1'b0;
            state_r  <= ST_FETCH;
            imem_req <= aligned(redir_valid ? redir_pc : req_addr_r);
          end else begin
            imem_req <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner sequences and
// random traffic checked against a transaction-level fetch model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, flush_valid, imem_ack;
  logic [31:0] redir_pc, flush_pc, imem_rdata;
  logic        imem_req, if_valid, if_adel;
  logic [31:0] imem_addr, if_pc, if_instr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_adel(if_adel)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } word_t;

  // Reference model: the output slot, a held-word queue, pending-redirect queue,
  // the address being fetched and whether its reply is to be squashed.
  word_t       m_out;
  word_t       m_held[$];
  logic [31:0] m_pend[$];
  logic        m_fetching, m_req, m_squash;
  logic [31:0] m_addr, m_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic is_al(input logic [31:0] a);
    return (a[1:0] == 2'b00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out      = '{1'b0, 32'h0, 32'h0, 1'b0};
    m_held.delete();
    m_pend.delete();
    m_fetching = 1'b1;
    m_req      = 1'b0;
    m_squash   = 1'b0;
    m_addr     = 32'h0000_3000;
    m_next     = 32'h0000_3000;
  endtask

  task automatic model_step();
    logic        accept, room, got, busy;
    logic [31:0] tgt;
    word_t       w;
    accept = m_out.v && !stall;
    room   = !m_out.v || accept;
    if (reset) begin
      model_reset();
    end else if (flush_valid) begin
      busy = m_fetching && m_req && !imem_ack;
      m_out.v = 1'b0;
      m_held.delete();
      m_pend.delete();
      m_next = flush_pc;
      m_fetching = 1'b1;
      if (busy) m_squash = 1'b1;
      else begin
        m_squash = 1'b0;
        m_addr = flush_pc;
        m_req = is_al(flush_pc);
      end
    end else if (m_fetching) begin
      got = (m_req && imem_ack) || !is_al(m_addr);
      if (got && m_squash) begin
        m_squash = 1'b0;
        m_addr = m_next;
        m_req = is_al(m_next);
        if (accept) m_out.v = 1'b0;
      end else if (got) begin
        w = is_al(m_addr) ? '{1'b1, m_addr, mem_word(m_addr), 1'b0}
                          : '{1'b1, m_addr, 32'h0, 1'b1};
        if (redir_valid) tgt = redir_pc;
        else if (m_pend.size() != 0) tgt = m_pend[0];
        else tgt = m_next + 32'd4;
        if (!redir_valid) m_pend.delete();
        if (room) begin
          m_out = w;
          m_req = is_al(tgt);
        end else begin
          m_held.push_back(w);
          m_fetching = 1'b0;
          m_req = 1'b0;
        end
        m_next = tgt;
        m_addr = tgt;
      end else begin
        if (redir_valid && !m_squash) begin
          m_pend.delete();
          m_pend.push_back(redir_pc);
        end
        m_req = 1'b1;
        if (accept) m_out.v = 1'b0;
      end
    end else begin
      if (redir_valid) begin
        m_next = redir_pc;
        m_addr = redir_pc;
      end
      if (room) begin
        m_out = m_held.pop_front();
        m_fetching = 1'b1;
        m_req = is_al(m_addr);
      end else begin
        m_req = 1'b0;
      end
    end
  endtask

  task automatic compare_model();
    check("model_req", 32'(imem_req), 32'(m_req));
    check("model_addr", imem_addr, m_addr);
    check("model_valid", 32'(if_valid), 32'(m_out.v));
    if (m_out.v) begin
      check("model_pc", if_pc, m_out.pc);
      check("model_instr", if_instr, m_out.instr);
      check("model_adel", 32'(if_adel), 32'(m_out.adel));
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                       input logic fl, input logic [31:0] fp, input logic a);
    reset       = r;
    stall       = s;
    redir_valid = rd;
    redir_pc    = rp;
    flush_valid = fl;
    flush_pc    = fp;
    imem_ack    = a & imem_req;
    imem_rdata  = imem_ack ? mem_word(imem_addr) : 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic        rst, stl, rd;
    logic [31:0] rpc;
    logic        ack, exp_req;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[15];

  initial begin
    logic        rr, rs, rf, ra;
    logic [31:0] rp, fp;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h3000, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h3000, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3000, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3004, 1'b1, 32'h3000};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3008, 1'b1, 32'h3004};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h300C, 1'b1, 32'h3008};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h3000, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3000, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3004, 1'b1, 32'h3000};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 1'b1, 32'h3004, 1'b0, 32'h0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3004, 1'b0, 32'h0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3004, 1'b0, 32'h0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3100, 1'b1, 32'h3004};
    vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3104, 1'b1, 32'h3100};
    vt[14] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h3104, 1'b0, 32'h0};

    model_reset();
    // Streaming after reset, then delayed ack with a delay-slot redirect.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].rst, vt[i].stl, vt[i].rd, vt[i].rpc, 1'b0, 32'h0, vt[i].ack);
      tick();
      check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vt[i].exp_req));
      check($sformatf("vec%0d_addr", i), imem_addr, vt[i].exp_addr);
      check($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vt[i].exp_v));
      if (vt[i].exp_v) check($sformatf("vec%0d_pc", i), if_pc, vt[i].exp_pc);
    end

    // Stall with memory acking: one word parks in HOLD, stream resumes intact.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    check("stall_pre_pc", if_pc, 32'h3104);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
      check("stall_req", 32'(imem_req), 32'h0);
      check("stall_pc", if_pc, 32'h3104);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    check("stall_rel_pc", if_pc, 32'h3108);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    check("stall_next_pc", if_pc, 32'h310C);

    // Flush while 0x3008 is outstanding; its late ack is discarded.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4180, 1'b0); tick();
    check("flush_valid", 32'(if_valid), 32'h0);
    check("flush_addr_held", imem_addr, 32'h3008);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    check("flush_drop_valid", 32'(if_valid), 32'h0);
    check("flush_new_addr", imem_addr, 32'h4180);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    check("flush_first_pc", if_pc, 32'h4180);

    // Redirect to a misaligned target raises adel without a memory request.
    drive(1'b0, 1'b0, 1'b1, 32'h3102, 1'b0, 32'h0, 1'b1); tick();
    check("mis_req", 32'(imem_req), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    check("mis_pc", if_pc, 32'h3102);
    check("mis_adel", 32'(if_adel), 32'h1);
    check("mis_instr", if_instr, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b0); tick();

    // Reset taken mid-HOLD with a redirect still parked.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b1, 32'h3200, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 32'h3300, 1'b0, 32'h0, 1'b1); tick();
    check("hold_req", 32'(imem_req), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); tick();
    check("rst_first_addr", imem_addr, 32'h3000);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); tick();
    check("rst_pend_cleared", imem_addr, 32'h3004);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(0, 399) == 0);
      rs = ($urandom_range(0, 9) < 3);
      rf = ($urandom_range(0, 39) == 0);
      ra = ($urandom_range(0, 9) < 6);
      rp = 32'h3000 + 32'($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 15) == 0) rp = rp + 32'd2;
      fp = 32'h4000 + 32'($urandom_range(0, 255) << 2);
      drive(rr, rs, (m_pend.size() == 0) && !m_squash && ($urandom_range(0, 11) == 0),
            rp, rf, fp, ra);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller. Owns the architectural PC register and drives the instruction-memory request/ack handshake.
- Applies next-PC redirects computed in D (branch, j, jr) with MIPS delay-slot semantics, and applies E-stage flushes (exception, eret).
- Sits between the next-PC logic, instruction memory and the F/D pipeline register. Its output register is the IF stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  downstream (F/D) not accepting this cycle.
- redir_valid  in  1  D-stage redirect (taken branch, j, jr) this cycle.
- redir_pc  in  32  redirect target.
- flush_valid  in  1  E-stage flush (exception/eret); highest priority.
- flush_pc  in  32  flush target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  instruction data valid this cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  IF output register holds an instruction.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  fetched instruction.
- if_adel  out  1  if_pc[1:0]!=0 (misaligned fetch; if_instr forced to 0).

Behaviour:
- State: FETCH (request outstanding), HOLD (word fetched, output register occupied).
- Registers: pc (next address to request), req_addr, pend_v/pend_pc (one-entry redirect buffer), drop, hold_v/hold_pc/hold_instr.
- Reset (synchronous):
  - state=FETCH, pc=req_addr=RESET_PC.
  - imem_req=0, if_valid=0, if_pc=0, if_instr=0, if_adel=0.
  - pend_v=0, drop=0, hold_v=0.
  - First request is issued the cycle after reset deasserts.
- Definitions:
  - consume = if_valid & ~stall.
  - out_free = ~if_valid | consume.
  - nxt = pend_v ? pend_pc : pc+4 (32-bit wrap).
- FETCH:
  - imem_req=1, imem_addr=req_addr.
  - Misaligned req_addr: no request is issued. Treat as immediate ack with rdata=0 and adel=1.
  - On ack with drop=1: discard the word, clear drop, request pc next cycle.
  - On ack with out_free: load if_* from {req_addr, rdata}.
  - On ack without out_free: load the hold buffer and go to HOLD.
  - On every non-dropped ack:
    - Redirect this same cycle: pc/req_addr <= redir_pc.
    - Otherwise: pc/req_addr <= nxt, and clear pend_v.
  - No ack while redir_valid: pend_v <= 1, pend_pc <= redir_pc. The in-flight word is the delay slot and is delivered.
  - Latency: ack in cycle N gives if_valid in N+1. The next request is issued in N+1, so back-to-back zero-wait memory gives 1 instruction/cycle.
- HOLD:
  - imem_req=0.
  - When out_free: move hold to if_*, clear hold_v, return to FETCH.
  - redir_valid in HOLD: pc/req_addr <= redir_pc directly. No request is in flight, so the held word is the delay slot.
- Output register: when consume and no new load, if_valid <= 0.
- Flush (overrides everything in the same cycle):
  - if_valid <= 0, hold_v <= 0, pend_v <= 0.
  - pc <= flush_pc, state <= FETCH.
  - If a request is outstanding without ack this cycle: drop <= 1 and req_addr stays unchanged until the ack. After the dropped ack, req_addr <= flush_pc.
  - Otherwise: req_addr <= flush_pc.
- Simultaneous flush+redirect: flush wins and the redirect is lost.
- Simultaneous stall+ack with occupied output: goes to HOLD, nothing is lost.
- A second redir_valid while pend_v=1 overwrites pend_pc. Upstream never issues two without an intervening ack.

Test Plan:
1. Reset, then ack every cycle with rdata=addr -> if_pc sequence 0x3000, 0x3004, 0x3008, one per cycle; imem_req=0 during reset.
2. Ack delayed 3 cycles on 0x3004, redir_valid(0x3100) in the 1st wait cycle -> if_pc 0x3004 (delay slot), then 0x3100; imem_addr held 0x3004 throughout the wait.
3. stall=1 for 4 cycles with ack every cycle -> exactly one word held in HOLD, imem_req=0; after release if_pc sequence continues with no gap, duplicate or loss.
4. flush_valid(0x4180) while 0x3008 is outstanding, ack 2 cycles later -> 0x3008 word never appears, if_valid=0; next delivered if_pc=0x4180.
5. redir_pc=0x3102 -> if_pc=0x3102, if_adel=1, if_instr=0, imem_req not asserted for that address.
6. Reset asserted mid-HOLD with pend_v=1 -> next cycle if_valid=0, pend cleared; first fetch at 0x3000.
